// File: rtl/dcache_ctrl_fsm.sv
// dcache_ctrl_fsm: write-back / write-allocate data-cache controller for the
// MEM stage. Sequences dirty-victim writeback, burst refill and uncached IO
// accesses over a per-word req/ack memory handshake.
// Optional perf counters enabled by defining DCACHE_PERF_CNT_EN.
module dcache_ctrl_fsm #(
  parameter int WORDS_PER_LINE = 4,
  parameter int IDX_W          = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1,
  parameter int CNT_W          = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MEM_READ2,
  input  logic             MEM_WRITE2,
  input  logic             addr_is_io,
  input  logic             hit,
  input  logic             victim_dirty,
  input  logic             mem_ack,
  output logic             miss_stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       mem_addr_sel,
  output logic [IDX_W-1:0] word_idx,
  output logic             fill_we,
  output logic             tag_update,
  output logic             set_dirty,
  output logic             io_latch,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WB   = 3'd1;
  localparam logic [2:0] S_RF   = 3'd2;
  localparam logic [2:0] S_IO   = 3'd3;
  localparam logic [2:0] S_IOD  = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             acc;
  logic             last;

  assign acc  = MEM_READ2 | MEM_WRITE2;
  // With one word per line the counter never leaves 0, so every ack is the last.
  assign last = (cnt_q == LAST_IDX);

  // Next-state and output decode; everything is forced low while RST is high.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    miss_stall   = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 2'b00;
    word_idx     = '0;
    fill_we      = 1'b0;
    tag_update   = 1'b0;
    set_dirty    = 1'b0;
    io_latch     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          if (addr_is_io) begin
            miss_stall = 1'b1;
            state_d    = S_IO;
          end else if (hit) begin
            set_dirty = MEM_WRITE2;
          end else begin
            miss_stall = 1'b1;
            cnt_d      = '0;
            state_d    = victim_dirty ? S_WB : S_RF;
          end
        end
      end
      S_WB: begin
        miss_stall   = 1'b1;
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr_sel = 2'b01;
        word_idx     = cnt_q;
        if (mem_ack) begin
          if (last) begin
            cnt_d   = '0;
            state_d = S_RF;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      S_RF: begin
        miss_stall   = 1'b1;
        mem_req      = 1'b1;
        mem_addr_sel = 2'b10;
        word_idx     = cnt_q;
        fill_we      = mem_ack;
        if (mem_ack) begin
          if (last) begin
            tag_update = 1'b1;
            cnt_d      = '0;
            state_d    = S_IDLE;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      S_IO: begin
        miss_stall = 1'b1;
        mem_req    = 1'b1;
        mem_we     = MEM_WRITE2;
        if (mem_ack) begin
          io_latch = ~MEM_WRITE2;
          state_d  = S_IOD;
        end
      end
      S_IOD: begin
        // One unstalled cycle lets the IO instruction retire without re-issue.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (RST) begin
      miss_stall   = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 2'b00;
      word_idx     = '0;
      fill_we      = 1'b0;
      tag_update   = 1'b0;
      set_dirty    = 1'b0;
      io_latch     = 1'b0;
    end
  end

  // State and word counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
  logic             ev_hit, ev_miss, ev_wb;

  assign ev_hit  = (state_q == S_IDLE) & acc & ~addr_is_io & hit;
  assign ev_miss = (state_q == S_IDLE) & acc & ~addr_is_io & ~hit;
  assign ev_wb   = (state_q == S_WB) & mem_ack & last;

  // Event counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (ev_hit)  hit_cnt_q  <= hit_cnt_q  + CNT_W'(1);
      if (ev_miss) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      if (ev_wb)   wb_cnt_q   <= wb_cnt_q   + CNT_W'(1);
    end
  end

  assign hit_cnt  = RST ? '0 : hit_cnt_q;
  assign miss_cnt = RST ? '0 : miss_cnt_q;
  assign wb_cnt   = RST ? '0 : wb_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
  assign wb_cnt   = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl_fsm.sv
// Directed bench for dcache_ctrl_fsm (WORDS_PER_LINE=4).
module tb_dcache_ctrl_fsm;
  localparam int WPL   = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 32;

  logic             CLK = 1'b0;
  logic             RST, MEM_READ2, MEM_WRITE2, addr_is_io, hit, victim_dirty, mem_ack;
  logic             miss_stall, mem_req, mem_we, fill_we, tag_update, set_dirty, io_latch;
  logic [1:0]       mem_addr_sel;
  logic [IDX_W-1:0] word_idx;
  logic [CNT_W-1:0] hit_cnt, miss_cnt, wb_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  dcache_ctrl_fsm #(.WORDS_PER_LINE(WPL), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .MEM_READ2(MEM_READ2), .MEM_WRITE2(MEM_WRITE2),
    .addr_is_io(addr_is_io), .hit(hit), .victim_dirty(victim_dirty), .mem_ack(mem_ack),
    .miss_stall(miss_stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .word_idx(word_idx), .fill_we(fill_we),
    .tag_update(tag_update), .set_dirty(set_dirty), .io_latch(io_latch),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic rd, input logic wr, input logic io,
                     input logic h, input logic vd, input logic ack);
    MEM_READ2 = rd; MEM_WRITE2 = wr; addr_is_io = io;
    hit = h; victim_dirty = vd; mem_ack = ack;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Packs the memory-side outputs for compact checks: {req,we,sel[1:0],idx[1:0],fill,tag}
  function automatic logic [31:0] mside();
    return {24'd0, mem_req, mem_we, mem_addr_sel, word_idx, fill_we, tag_update};
  endfunction

  task automatic chk_perf(input string tag, input int h, input int m, input int w);
`ifdef DCACHE_PERF_CNT_EN
    chk({tag, "_hit_cnt"},  hit_cnt,  32'(h));
    chk({tag, "_miss_cnt"}, miss_cnt, 32'(m));
    chk({tag, "_wb_cnt"},   wb_cnt,   32'(w));
`else
    chk({tag, "_hit_cnt"},  hit_cnt,  32'd0);
    chk({tag, "_miss_cnt"}, miss_cnt, 32'd0);
    chk({tag, "_wb_cnt"},   wb_cnt,   32'd0);
`endif
  endtask

  initial begin
    RST = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    tick(); tick();
    // Outputs forced low during reset even with a miss presented.
    drv(1, 0, 0, 0, 1, 1);
    chk("rst_stall", miss_stall, 0);
    chk("rst_mside", mside(), 0);
    chk_perf("rst", 0, 0, 0);
    tick();
    RST = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    chk("idle_stall", miss_stall, 0);
    chk("idle_mside", mside(), 0);

    // Read hit for three cycles.
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 0, 1, 0, 0);
      chk("rdhit_stall", miss_stall, 0);
      chk("rdhit_dirty", set_dirty, 0);
      tick();
    end
    chk_perf("rdhit", 3, 0, 0);

    // Store hit marks line dirty without stall.
    drv(0, 1, 0, 1, 0, 0);
    chk("sthit_stall", miss_stall, 0);
    chk("sthit_dirty", set_dirty, 1);
    tick();

    // Clean read miss: refill 4 words, one wait cycle before each ack.
    drv(1, 0, 0, 0, 0, 0);
    chk("cmiss_stall", miss_stall, 1);
    chk("cmiss_mside", mside(), 0);
    tick();
    for (int w = 0; w < WPL; w++) begin
      drv(1, 0, 0, 0, 0, 0);
      chk("rf_wait", mside(), {24'd0, 4'b1010, 2'(w), 2'b00});
      chk("rf_wait_stall", miss_stall, 1);
      tick();
      drv(1, 0, 0, 0, 0, 1);
      chk("rf_ack", mside(), {24'd0, 4'b1010, 2'(w), 1'b1, (w == WPL-1)});
      tick();
    end
    drv(1, 0, 0, 1, 0, 0);
    chk("cmiss_done_stall", miss_stall, 0);
    chk("cmiss_done_mside", mside(), 0);
    tick();
    chk_perf("cmiss", 5, 1, 0);

    // Dirty store miss: 4 writebacks then 4 refills, then store completes.
    drv(0, 1, 0, 0, 1, 0);
    chk("dmiss_stall", miss_stall, 1);
    chk("dmiss_dirty", set_dirty, 0);
    tick();
    for (int w = 0; w < WPL; w++) begin
      drv(0, 1, 0, 0, 1, 1);
      chk("wb_word", mside(), {24'd0, 4'b1101, 2'(w), 2'b00});
      tick();
    end
    for (int w = 0; w < WPL; w++) begin
      drv(0, 1, 0, 0, 0, 1);
      chk("rf2_word", mside(), {24'd0, 4'b1010, 2'(w), 1'b1, (w == WPL-1)});
      tick();
    end
    drv(0, 1, 0, 1, 0, 0);
    chk("dmiss_done_stall", miss_stall, 0);
    chk("dmiss_done_dirty", set_dirty, 1);
    tick();
    chk_perf("dmiss", 6, 2, 1);

    // IO load on an address that also hits.
    drv(1, 0, 1, 1, 0, 0);
    chk("io_stall", miss_stall, 1);
    chk("io_nodirty", set_dirty, 0);
    tick();
    chk("io_wait", mside(), {24'd0, 4'b1000, 4'b0000});
    chk("io_wait_latch", io_latch, 0);
    tick();
    drv(1, 0, 1, 1, 0, 1);
    chk("io_ack_latch", io_latch, 1);
    chk("io_ack_mside", mside(), {24'd0, 4'b1000, 4'b0000});
    tick();
    drv(1, 0, 1, 1, 0, 0);
    chk("iodone_stall", miss_stall, 0);
    chk("iodone_req", mem_req, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    chk("io_back_idle", mside(), 0);
    tick();

    // IO with both read and write: write wins.
    drv(1, 1, 1, 0, 0, 0);
    tick();
    chk("iowr_we", mem_we, 1);
    drv(1, 1, 1, 0, 0, 1);
    chk("iowr_latch", io_latch, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    chk("iowr_done_stall", miss_stall, 0);
    tick();
    chk_perf("io", 6, 2, 1);

    // Reset in the middle of a refill.
    drv(1, 0, 0, 0, 0, 0);
    tick();
    for (int w = 0; w < 2; w++) begin
      drv(1, 0, 0, 0, 0, 1);
      tick();
    end
    drv(1, 0, 0, 0, 0, 0);
    chk("mid_idx", word_idx, 2);
    RST = 1'b1;
    #1;
    chk("mid_rst_req", mem_req, 0);
    tick();
    RST = 1'b0;
    drv(0, 0, 0, 0, 0, 1);
    chk("post_rst_mside", mside(), 0);
    chk("post_rst_stall", miss_stall, 0);
    chk_perf("post_rst", 0, 0, 0);
    tick();
    drv(1, 0, 0, 0, 0, 0);
    chk("late_ack_stall", miss_stall, 1);
    tick();
    chk("restart_mside", mside(), {24'd0, 4'b1010, 4'b0000});
    chk_perf("restart", 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl_fsm.md
Name: dcache_ctrl_fsm

Overview:
- Parametrised write-back, write-allocate data-cache controller FSM for the MEM stage of the MCU pipeline.
- Supports multi-word cache lines and a per-word req/ack handshake to main memory.
- Sequences dirty-victim writeback, burst line refill and uncached IO accesses.
- Drives pipeline stall, cache array write enables, tag/dirty updates and memory-side controls.

Parameters:
- WORDS_PER_LINE, 4, words per cache line; power of two, >=1.
- IDX_W, (WORDS_PER_LINE>1 ? $clog2(WORDS_PER_LINE) : 1), width of the word-index counter; derived, not overridden.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- MEM_READ2  in  1  MEM-stage load.
- MEM_WRITE2  in  1  MEM-stage store; wins over MEM_READ2 if both are high.
- addr_is_io  in  1  access targets IO space (uncached).
- hit  in  1  tag match on a valid line (combinational from the tag array).
- victim_dirty  in  1  the indexed line is valid and dirty.
- mem_ack  in  1  memory completed the current word; ignored while mem_req=0.
- miss_stall  out  1  freezes the pipeline.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = memory write, 0 = memory read.
- mem_addr_sel  out  2  00 = CPU address, 01 = victim line base + word_idx, 10 = refill line base + word_idx.
- word_idx  out  IDX_W  current word within the line.
- fill_we  out  1  write the memory read word into the cache at word_idx.
- tag_update  out  1  write the new tag, set valid, clear dirty.
- set_dirty  out  1  mark the indexed line dirty (store hit).
- io_latch  out  1  capture IO read data into the MEM/WB register.
- hit_cnt, miss_cnt, wb_cnt  out  CNT_W each  performance counters.

Behaviour:
- Reset: RST=1 at a clock edge sets the state to IDLE, the counter to 0 and the perf counters to 0. All outputs are 0 during and after reset. An in-flight memory transaction is abandoned, and late mem_ack pulses are ignored because mem_req=0.
- States: IDLE, WRITEBACK, REFILL, IO, IO_DONE. Outputs are Moore/Mealy combinational from state, the counter and the inputs.
- Access definition: acc = MEM_READ2 | MEM_WRITE2.
- IDLE, no acc: all outputs 0; stay in IDLE.
- IDLE, acc & addr_is_io: IO takes priority over hit. miss_stall=1; next state IO.
- IDLE, acc & !io & hit: no stall; set_dirty=MEM_WRITE2; stay in IDLE. Zero-latency hit.
- IDLE, acc & !io & !hit: miss_stall=1; next state WRITEBACK if victim_dirty, else REFILL. The counter is 0 on entry.
- WRITEBACK: miss_stall=1, mem_req=1, mem_we=1, mem_addr_sel=01, word_idx=counter.
  - On mem_ack: counter increments.
  - At counter==WORDS_PER_LINE-1 with mem_ack: counter wraps to 0 and next state is REFILL.
- REFILL: miss_stall=1, mem_req=1, mem_we=0, mem_addr_sel=10, word_idx=counter, fill_we=mem_ack.
  - At the last word with mem_ack: tag_update=1, counter=0, next state IDLE.
- Post-refill: the stall holds until IDLE re-evaluates hit, which is now 1. A store then completes there with set_dirty (write-allocate). Refill latency is WORDS_PER_LINE acks; a dirty miss costs 2*WORDS_PER_LINE acks.
- IO: miss_stall=1, mem_req=1, mem_we=MEM_WRITE2, mem_addr_sel=00, word_idx=0. On mem_ack: io_latch=!MEM_WRITE2 and next state IO_DONE.
- IO_DONE: miss_stall=0 for exactly one cycle so the IO instruction retires; next state IDLE. This prevents re-issuing the same IO access.
- Wait states: mem_ack may arrive any number of cycles after mem_req. All outputs hold steady while waiting.
- WORDS_PER_LINE=1: WRITEBACK and REFILL each take a single ack; word_idx is constant 0.
- If acc drops during WRITEBACK or REFILL (cannot happen under stall), the sequence still completes.

Optional Feature:
- Macro: DCACHE_PERF_CNT_EN.
- When defined, each counter increments by 1 per event and wraps modulo 2^CNT_W:
  - hit_cnt: each IDLE cycle with a cacheable hit access.
  - miss_cnt: each IDLE→WRITEBACK or IDLE→REFILL transition.
  - wb_cnt: each WRITEBACK→REFILL transition.
- When undefined: the counters are tied to 0, no flops are inferred, and the ports remain present.

Test Plan:
- Read hit: RST then MEM_READ2=1, hit=1 for 3 cycles -> miss_stall=0 throughout, state stays IDLE; hit_cnt=3 if DCACHE_PERF_CNT_EN.
- Clean read miss, WORDS_PER_LINE=4, mem_ack 2 cycles after each req -> REFILL with word_idx 0,1,2,3; fill_we on each ack; tag_update on the 4th ack; back to IDLE; stall drops once hit=1.
- Dirty store miss -> 4 WRITEBACK words (mem_we=1, sel=01), then 4 REFILL words (sel=10), then IDLE with set_dirty=1 and miss_stall=0; wb_cnt=1, miss_cnt=1.
- IO load with addr_is_io=1 and hit=1 -> IO state (mem_we=0, sel=00); on ack io_latch=1; IO_DONE gives one cycle with miss_stall=0; then IDLE; no cache writes.
- RST asserted at REFILL word 2 -> next cycle IDLE, counter 0, mem_req=0; a following mem_ack has no effect; a new miss restarts at word_idx=0.
- MEM_READ2 and MEM_WRITE2 both high on an IO address -> mem_we=1 (write priority).
